// File: rtl/dh_cal_stream.sv
// Streaming Dh calculator: per group of ROWS*COLS_PER_DH complex Hq samples,
// Dh = sum(re^2 + im^2) >> Q, saturated to N-bit signed, with valid/ready on both sides.
module dh_cal_stream #(
   parameter int unsigned Q           = 8,
   parameter int unsigned N           = 16,
   parameter int unsigned ROWS        = 4,
   parameter int unsigned COLS_PER_DH = 2,
   parameter int unsigned NUM_DH      = 16,
   parameter int unsigned ACC_W       = 2*N + 1 + $clog2(ROWS*COLS_PER_DH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      Dh_en,
   output logic                      in_ready,
   input  logic [N-1:0]              in_real,
   input  logic [N-1:0]              in_im,
   output logic [N-1:0]              Dh_out,
   output logic [$clog2(NUM_DH)-1:0] Dh_index,
   output logic                      Dh_result_valid,
   input  logic                      Dh_out_ready,
   output logic                      Dh_sat
);

   localparam int unsigned GRP   = ROWS * COLS_PER_DH;
   localparam int unsigned CNT_W = (GRP > 1) ? $clog2(GRP) : 1;
   localparam int unsigned P_W   = 2*N + 1;
   localparam int unsigned IDX_W = $clog2(NUM_DH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DH - 1);
   localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

   logic [CNT_W-1:0]        cnt;
   logic                    s1_valid;
   logic                    s1_last;
   logic [P_W-1:0]          p;
   logic [ACC_W-1:0]        acc;

   logic signed [2*N-1:0]   rr_c;
   logic signed [2*N-1:0]   ii_c;
   logic [P_W-1:0]          p_c;
   logic [ACC_W-1:0]        sum_c;
   logic [ACC_W-1:0]        shr_c;
   logic                    sat_c;
   logic [N-1:0]            dh_c;
   logic                    stall_c;
   logic                    accept_c;
   logic                    load_c;
   logic                    xfer_c;
   logic                    wrap_c;

   // Datapath: squared magnitude, running sum and saturated Q-format result
   always_comb begin
      rr_c  = (2*N)'($signed(in_real)) * (2*N)'($signed(in_real));
      ii_c  = (2*N)'($signed(in_im)) * (2*N)'($signed(in_im));
      p_c   = P_W'($unsigned(rr_c)) + P_W'($unsigned(ii_c));
      sum_c = acc + ACC_W'(p);
      shr_c = sum_c >> Q;
      sat_c = (shr_c > SAT_MAX);
      dh_c  = sat_c ? N'(SAT_MAX) : N'(shr_c);
   end

   // Handshake: only a finished group waiting on a full output register stalls
   always_comb begin
      stall_c  = s1_valid & s1_last & Dh_result_valid & ~Dh_out_ready;
      in_ready = ~stall_c;
      accept_c = Dh_en & ~stall_c;
      load_c   = s1_valid & s1_last & ~stall_c;
      xfer_c   = Dh_result_valid & Dh_out_ready;
      wrap_c   = xfer_c & (Dh_index == IDX_LAST);
   end

   // Stage 1: per-sample power and group position
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         p        <= '0;
      end else if (!stall_c) begin
         s1_valid <= accept_c;
         if (accept_c) begin
            p       <= p_c;
            s1_last <= (cnt == CNT_LAST);
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
         end
      end
   end

   // Stage 2: accumulate, publish result, track index and sticky saturation
   always_ff @(posedge clk) begin
      if (rst) begin
         acc             <= '0;
         Dh_out          <= '0;
         Dh_index        <= '0;
         Dh_result_valid <= 1'b0;
         Dh_sat          <= 1'b0;
      end else begin
         if (s1_valid && !s1_last) begin
            acc <= sum_c;
         end else if (load_c) begin
            acc <= '0;
         end

         if (load_c) begin
            Dh_out          <= dh_c;
            Dh_result_valid <= 1'b1;
         end else if (xfer_c) begin
            Dh_result_valid <= 1'b0;
         end

         if (xfer_c) begin
            Dh_index <= wrap_c ? '0 : Dh_index + IDX_W'(1);
         end

         Dh_sat <= (load_c & sat_c) | (Dh_sat & ~wrap_c);
      end
   end

endmodule

// File: tb/tb_dh_cal_stream.sv
// Bench for dh_cal_stream: directed test-plan steps plus randomized traffic,
// checked against a group-sum reference model held in a result queue.
module tb_dh_cal_stream;

   localparam int Q      = 8;
   localparam int N      = 16;
   localparam int NUM_DH = 16;
   localparam int GRP    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Dh_en = 1'b0;
   logic        in_ready;
   logic [15:0] in_real = '0;
   logic [15:0] in_im = '0;
   logic [15:0] Dh_out;
   logic [3:0]  Dh_index;
   logic        Dh_result_valid;
   logic        Dh_out_ready = 1'b1;
   logic        Dh_sat;

   always #5 clk = ~clk;

   dh_cal_stream #(.Q(Q), .N(N), .ROWS(4), .COLS_PER_DH(2), .NUM_DH(NUM_DH)) dut (
      .clk             (clk),
      .rst             (rst),
      .Dh_en           (Dh_en),
      .in_ready        (in_ready),
      .in_real         (in_real),
      .in_im           (in_im),
      .Dh_out          (Dh_out),
      .Dh_index        (Dh_index),
      .Dh_result_valid (Dh_result_valid),
      .Dh_out_ready    (Dh_out_ready),
      .Dh_sat          (Dh_sat)
   );

   typedef struct {
      int val;
      int idx;
      bit sat;
      int done;
   } res_t;

   int     checks = 0;
   int     failures = 0;

   // Reference model: completed groups awaiting transfer, partial group, frame state
   res_t   q[$];
   longint gsum;
   int     gcnt;
   int     nidx;
   bit     fsat;
   int     t = 0;

   // DUT outputs as observed in the most recent tick
   logic        o_valid;
   logic        o_ready;
   logic [15:0] o_out;
   logic [3:0]  o_idx;
   logic        o_sat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      gsum = 0;
      gcnt = 0;
      nidx = 0;
      fsat = 1'b0;
   endtask

   task automatic do_reset();
      Dh_en = 1'b0;
      Dh_out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      t++;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(Dh_result_valid), 32'd0);
      check("rst_out", 32'(Dh_out), 32'd0);
      check("rst_index", 32'(Dh_index), 32'd0);
      check("rst_sat", 32'(Dh_sat), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   // One clock cycle: drive, compare against the model, then advance the model
   task automatic tick(input logic en, input logic [15:0] re, input logic [15:0] im,
                       input logic rdy);
      bit     ev, eir, acc, xfer, s;
      res_t   r;
      longint v;
      int     sr, si;
      Dh_en = en;
      in_real = re;
      in_im = im;
      Dh_out_ready = rdy;
      #1;
      ev  = (q.size() > 0) && (q[0].done < t);
      eir = !((q.size() >= 2) && !rdy);
      o_valid = Dh_result_valid;
      o_ready = in_ready;
      o_out = Dh_out;
      o_idx = Dh_index;
      o_sat = Dh_sat;
      check("in_ready", 32'(in_ready), 32'(eir));
      check("valid", 32'(Dh_result_valid), 32'(ev));
      if (ev) begin
         check("Dh_out", 32'(Dh_out), 32'(q[0].val));
         check("Dh_index", 32'(Dh_index), 32'(q[0].idx));
         check("Dh_sat", 32'(Dh_sat), 32'(q[0].sat));
      end
      acc  = en && eir;
      xfer = ev && rdy;
      @(posedge clk);
      t++;
      if (xfer) void'(q.pop_front());
      if (acc) begin
         sr = $signed(re);
         si = $signed(im);
         gsum += longint'(sr * sr) + longint'(si * si);
         gcnt++;
         if (gcnt == GRP) begin
            v = gsum >>> Q;
            s = (v > 32767);
            if (s) v = 32767;
            r.val = int'(v);
            r.idx = nidx;
            nidx = (nidx + 1) % NUM_DH;
            if (r.idx == 0) fsat = 1'b0;
            fsat = fsat | s;
            r.sat = fsat;
            r.done = t;
            q.push_back(r);
            gsum = 0;
            gcnt = 0;
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [15:0] rnd_sample();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'($urandom_range(0, 1023)) - 16'd512;
   endfunction

   initial begin
      model_clear();
      @(negedge clk);

      // Unit-power samples, including first-result latency
      do_reset();
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("lat_one_cycle", 32'(o_valid), 32'd0);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("lat_two_cycles", 32'(o_valid), 32'd1);
      check("g1_out", 32'(o_out), 32'h0800);
      check("g1_index", 32'(o_idx), 32'd0);

      // Negative real part, fractional imaginary part
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'hFF00, 16'h0080, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("g2_out", 32'(o_out), 32'h0A00);
      check("g2_index", 32'(o_idx), 32'd1);

      // Saturation, then a small group keeps the sticky flag
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("g3_out", 32'(o_out), 32'h7FFF);
      check("g3_sat", 32'(o_sat), 32'd1);
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0080, 16'h0080, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("g4_out", 32'(o_out), 32'h0400);
      check("g4_sat", 32'(o_sat), 32'd1);

      // Output backpressure across two back-to-back groups
      do_reset();
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b0);
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0080, 16'h0080, 1'b0);
      tick(1'b0, 16'h0, 16'h0, 1'b0);
      check("bp_in_ready", 32'(o_ready), 32'd0);
      check("bp_hold_out", 32'(o_out), 32'h0800);
      tick(1'b1, 16'h0100, 16'h0000, 1'b0);
      check("bp_still_blocked", 32'(o_ready), 32'd0);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("bp_first_out", 32'(o_out), 32'h0800);
      check("bp_first_index", 32'(o_idx), 32'd0);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("bp_second_out", 32'(o_out), 32'h0400);
      check("bp_second_index", 32'(o_idx), 32'd1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("bp_drained", 32'(o_valid), 32'd0);

      // Reset in the middle of a group discards the partial sum
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b1);
      do_reset();
      for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("mid_rst_out", 32'(o_out), 32'h0800);
      check("mid_rst_index", 32'(o_idx), 32'd0);

      // Index wrap over a full frame plus one group
      do_reset();
      for (int g = 0; g < NUM_DH + 1; g++)
         for (int i = 0; i < GRP; i++) tick(1'b1, 16'h0100, 16'h0000, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("wrap_index", 32'(o_idx), 32'd0);
      check("wrap_out", 32'(o_out), 32'h0800);
      check("wrap_sat", 32'(o_sat), 32'd0);

      // Randomized traffic with occasional resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            tick($urandom_range(0, 4) != 0, rnd_sample(), rnd_sample(),
                 $urandom_range(0, 3) != 0);
         end
      end
      for (int c = 0; c < 8; c++) tick(1'b0, 16'h0, 16'h0, 1'b1);
      check("final_idle", 32'(o_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
